// File: rtl/console_pkg.sv
// console_pkg: shared constants, state encoding and glyph generator for the
// character console buffer.
//   COLS_W / ROWS_W : column / row address widths of the 16x16 grid
//   ADDR_W          : width of a buffer address {row, col}
//   BLANK_CODE      : code written by clear and by backspace
//   NL_CODE/BS_CODE : newline and backspace control codes
//   FONT_AW         : font ROM address width, {code[6:0], line[3:0]}
//   con_state_e     : FSM states of the buffer controller
package console_pkg;

    localparam int COLS_W  = 4;
    localparam int ROWS_W  = 4;
    localparam int ADDR_W  = COLS_W + ROWS_W;
    localparam int FONT_AW = 11;

    localparam logic [7:0] BLANK_CODE = 8'h20;
    localparam logic [7:0] NL_CODE    = 8'h0A;
    localparam logic [7:0] BS_CODE    = 8'h08;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } con_state_e;

    // Glyph content of the font ROM. Each row is derived from its address:
    // the 7-bit code shifted left one pixel, XORed with the line number
    // replicated in both nibbles, so every code/line pair is distinguishable.
    function automatic logic [7:0] font_pattern(input logic [FONT_AW-1:0] addr);
        return {addr[FONT_AW-1:4], 1'b0} ^ {addr[3:0], addr[3:0]};
    endfunction

endpackage

// File: rtl/char_console_buf_if.sv
// char_console_buf_if: write-side port of the character console buffer.
//   wr_valid  : write request (master)
//   wr_char   : character or control code (master)
//   wr_ready  : buffer can accept a write this cycle (slave)
//   clr       : one-cycle clear request (master)
//   busy      : clear in progress (slave)
//   dbg_state : current controller state, for observation only (slave)
//
// Handshake: a write transfers on a pclk edge where wr_valid && wr_ready.
// wr_char must be stable only while wr_valid && wr_ready. wr_ready is
// combinational and drops in any cycle where clr is high, so a clear
// presented together with a write always wins and the write is not taken.
interface char_console_buf_if;
    import console_pkg::*;

    logic       wr_valid;
    logic [7:0] wr_char;
    logic       wr_ready;
    logic       clr;
    logic       busy;
    con_state_e dbg_state;

    modport master (
        output wr_valid, wr_char, clr,
        input  wr_ready, busy, dbg_state
    );

    modport slave (
        input  wr_valid, wr_char, clr,
        output wr_ready, busy, dbg_state
    );

endinterface

// File: rtl/font_rom.sv
// font_rom: 2048x8 glyph ROM, synchronous read with one cycle of latency.
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset, forces data to 0
//   addr  : {code[6:0], line[3:0]}
//   data  : glyph row, bit 7 is the leftmost pixel
module font_rom
    import console_pkg::*;
(
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [FONT_AW-1:0] addr,
    output logic [7:0]         data
);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= font_pattern(addr);
        end
    end

endmodule

// File: rtl/char_console_buf.sv
// char_console_buf: 16x16 character store with cursor-driven writes and a
// two-stage read path (buffer, then font ROM) for the text-box drawer.
//   pclk        : pixel clock, the only clock
//   rst_n       : asynchronous active-low reset; starts a full clear
//   char_xy     : read address {row[3:0], col[3:0]}
//   char_line   : glyph line 0..15 within the character
//   char_pixels : glyph row for the request made 2 cycles earlier
//   wr          : write/clear port (see char_console_buf_if)
module char_console_buf
    import console_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 16,
    parameter logic [7:0] BLANK_CODE = console_pkg::BLANK_CODE
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] char_xy,
    input  logic [3:0]        char_line,
    output logic [7:0]        char_pixels,
    char_console_buf_if.slave wr
);

    localparam int                DEPTH    = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLS);

    logic [7:0]        mem [DEPTH];

    con_state_e        state;
    logic [ADDR_W-1:0] cursor;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;

    logic              wr_ready_int;
    logic              wr_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] cursor_nxt;

    logic [6:0]        rd_code;
    logic [3:0]        line_d;

    assign wr_ready_int = (state == ST_IDLE) && !wr.clr;
    assign wr_fire      = wr.wr_valid && wr_ready_int;

    assign wr.wr_ready  = wr_ready_int;
    assign wr.busy      = busy_q;
    assign wr.dbg_state = state;

    // Single buffer write port: the clear sweep owns it while clearing,
    // otherwise accepted writes use it (newline never writes).
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = cursor;
        mem_wdata  = wr.wr_char;
        cursor_nxt = cursor;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = BLANK_CODE;
        end else if (wr_fire) begin
            case (wr.wr_char)
                NL_CODE: begin
                    // Start of the next row; the top bits overflow so the
                    // last row wraps to row 0.
                    cursor_nxt = (cursor & ~COL_MASK) + COL_STEP;
                end
                BS_CODE: begin
                    cursor_nxt = (cursor == '0) ? '0 : cursor - ADDR_W'(1);
                    mem_we     = 1'b1;
                    mem_waddr  = cursor_nxt;
                    mem_wdata  = BLANK_CODE;
                end
                default: begin
                    mem_we     = 1'b1;
                    cursor_nxt = cursor + ADDR_W'(1);
                end
            endcase
        end
    end

    // Controller: clear sweep after reset or clr, then accept writes.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            cursor  <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cursor  <= '0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (wr.clr) begin
                        state   <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end else if (wr_fire) begin
                        cursor <= cursor_nxt;
                    end
                end
                default: begin
                    state  <= ST_CLEAR;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Buffer contents are not reset; the clear sweep blanks them.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read stage 1: the read samples the array before this edge's write,
    // so a same-address read/write returns the old code. Only the low 7
    // bits of the code address the font.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_code <= '0;
            line_d  <= '0;
        end else begin
            rd_code <= mem[char_xy][6:0];
            line_d  <= char_line;
        end
    end

    // Read stage 2: glyph lookup.
    font_rom u_font_rom (
        .pclk  (pclk),
        .rst_n (rst_n),
        .addr  ({rd_code, line_d}),
        .data  (char_pixels)
    );

endmodule

// File: tb/tb_char_console_buf.sv
// tb_char_console_buf: directed test of char_console_buf against a
// behavioural model of the character grid, cursor and clear timing.
module tb_char_console_buf;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_xy = 8'h00;
    logic [3:0] char_line = 4'h0;
    logic [7:0] char_pixels;

    char_console_buf_if wr_if ();

    int total = 0;
    int bad   = 0;

    // model: grid contents, which entries hold defined data, cursor, and
    // how many clear writes remain
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    int         m_cursor = 0;
    int         m_left   = 256;

    // scoreboard: {defined, expected pixels} per read request
    logic [8:0] exp_q [$];

    always #5 pclk = ~pclk;

    char_console_buf dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .char_xy     (char_xy),
        .char_line   (char_line),
        .char_pixels (char_pixels),
        .wr          (wr_if.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Glyph row of a code: the 7-bit code doubled, XOR the line times 0x11.
    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [3:0] line);
        logic [7:0] base;
        logic [7:0] stripe;
        base   = {1'b0, code[6:0]} * 8'd2;
        stripe = {4'h0, line} * 8'h11;
        return base ^ stripe;
    endfunction

    function automatic logic [7:0] fill_code(input int i);
        logic [7:0] c;
        c = 8'((i * 7 + 33) % 256);
        if (c == 8'h08 || c == 8'h0A) c = 8'h7E;
        return c;
    endfunction

    task automatic m_write(input logic [7:0] c);
        if (c == 8'h0A) begin
            m_cursor = ((m_cursor / 16 + 1) % 16) * 16;
        end else if (c == 8'h08) begin
            if (m_cursor > 0) m_cursor = m_cursor - 1;
            m_mem[m_cursor]   = 8'h20;
            m_known[m_cursor] = 1'b1;
        end else begin
            m_mem[m_cursor]   = c;
            m_known[m_cursor] = 1'b1;
            m_cursor = (m_cursor + 1) % 256;
        end
    endtask

    // Compare process: inputs are stable at the falling edge; decide what the
    // coming rising edge does and check outputs produced by earlier edges.
    always @(negedge pclk) begin
        logic [8:0] e;
        if (!rst_n) begin
            chk("rst_pixels", 32'(char_pixels), 32'h0);
            chk("rst_busy", 32'(wr_if.busy), 32'h1);
            chk("rst_ready", 32'(wr_if.wr_ready), 32'h0);
            exp_q.delete();
            m_left = 256;
        end else begin
            chk("busy", 32'(wr_if.busy), 32'(m_left > 0));
            chk("wr_ready", 32'(wr_if.wr_ready), 32'((m_left == 0) && !wr_if.clr));
            exp_q.push_back({m_known[char_xy], glyph(m_mem[char_xy], char_line)});
            if (exp_q.size() > 2) begin
                e = exp_q.pop_front();
                if (e[8]) chk("pixels", 32'(char_pixels), 32'(e[7:0]));
            end
            if (m_left > 0) begin
                m_mem[256 - m_left]   = 8'h20;
                m_known[256 - m_left] = 1'b1;
                m_left = m_left - 1;
                if (m_left == 0) m_cursor = 0;
            end else if (wr_if.clr) begin
                m_left = 256;
            end else if (wr_if.wr_valid) begin
                m_write(wr_if.wr_char);
            end
        end
    end

    task automatic write_char(input logic [7:0] c);
        int n;
        n = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = c;
        @(negedge pclk);
        while (!wr_if.wr_ready && n < 1000) begin
            @(negedge pclk);
            n++;
        end
        chk("write_accept_in_time", 32'(n < 1000), 32'h1);
        @(posedge pclk);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic measure_busy(input string name);
        int cnt;
        cnt = 0;
        while (wr_if.busy && cnt < 1000) begin
            cnt++;
            @(posedge pclk);
            #1;
        end
        chk(name, cnt, 256);
    endtask

    task automatic read_lit(input string name, input logic [7:0] xy,
                            input logic [3:0] line, input logic [7:0] exp);
        char_xy   = xy;
        char_line = line;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        chk(name, 32'(char_pixels), 32'(exp));
    endtask

    task automatic sweep_reads();
        for (int i = 0; i < 256; i++) begin
            char_xy   = 8'(i);
            char_line = 4'(i * 5);
            @(posedge pclk);
            #1;
        end
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic do_clear(input string name);
        wr_if.clr = 1'b1;
        #1;
        chk("clr_blocks_ready", 32'(wr_if.wr_ready), 32'h0);
        @(posedge pclk);
        #1;
        wr_if.clr = 1'b0;
        measure_busy(name);
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_char  = 8'h00;
        wr_if.clr      = 1'b0;

        // reset and power-up clear
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_pixels", 32'(char_pixels), 32'h0);
        chk("reset_busy", 32'(wr_if.busy), 32'h1);
        chk("reset_ready", 32'(wr_if.wr_ready), 32'h0);
        rst_n = 1'b1;
        measure_busy("reset_busy_len");
        sweep_reads();
        read_lit("blank_37_l3", 8'h37, 4'h3, 8'h73);

        // write and read back
        write_char(8'h41);
        write_char(8'h42);
        read_lit("A_l5", 8'h00, 4'h5, 8'hD7);
        read_lit("B_l5", 8'h01, 4'h5, 8'hD1);

        // newline, then wrap of the row through 15 more newlines
        write_char(8'h41);
        write_char(8'h0A);
        write_char(8'h43);
        read_lit("C_at_10", 8'h10, 4'h0, 8'h86);
        for (int i = 0; i < 15; i++) write_char(8'h0A);
        write_char(8'h44);
        read_lit("D_at_00", 8'h00, 4'h2, 8'hAA);

        // backspace
        do_clear("clr_busy_len");
        write_char(8'h58);
        write_char(8'h59);
        write_char(8'h08);
        read_lit("bs_blank_01", 8'h01, 4'h7, 8'h37);
        write_char(8'h5A);
        read_lit("Z_at_01", 8'h01, 4'h1, 8'hA5);
        for (int i = 0; i < 3; i++) write_char(8'h08);
        write_char(8'h51);
        read_lit("Q_at_00", 8'h00, 4'h0, 8'hA2);
        read_lit("bs_blank_01b", 8'h01, 4'h0, 8'h40);

        // clear and write in the same cycle: clear wins
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = 8'h4D;
        do_clear("clr_vs_wr_busy_len");
        wr_if.wr_valid = 1'b0;
        read_lit("dropped_01", 8'h01, 4'h4, 8'h04);
        read_lit("cleared_00", 8'h00, 4'h4, 8'h04);

        // fill all 256 entries, then the 257th wraps to 0
        for (int i = 0; i < 256; i++) write_char(fill_code(i));
        write_char(8'h57);
        read_lit("W_wraps_00", 8'h00, 4'h3, 8'h9D);
        read_lit("last_ff", 8'hFF, 4'h0, 8'h34);
        read_lit("high_code_10", 8'h10, 4'h0, 8'h22);
        sweep_reads();

        // same-address read and write in one cycle returns the old code
        char_xy        = 8'h01;
        char_line      = 4'h2;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = 8'h61;
        @(posedge pclk);
        #1;
        wr_if.wr_valid = 1'b0;
        @(posedge pclk);
        #1;
        chk("collision_old", 32'(char_pixels), 32'h72);
        @(posedge pclk);
        #1;
        chk("collision_new", 32'(char_pixels), 32'hE0);
        write_char(8'hC1);
        read_lit("C1_masked", 8'h02, 4'h5, 8'hD7);

        // reset in the middle of a clear
        char_xy   = 8'h00;
        char_line = 4'h1;
        wr_if.clr = 1'b1;
        @(posedge pclk);
        #1;
        wr_if.clr = 1'b0;
        repeat (99) @(posedge pclk);
        #1;
        chk("mid_clear_pixels", 32'(char_pixels), 32'h51);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pixels", 32'(char_pixels), 32'h0);
        chk("async_rst_busy", 32'(wr_if.busy), 32'h1);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        measure_busy("rst_mid_clear_busy_len");
        sweep_reads();

        repeat (3) @(posedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: run did not complete, limit 1000000 ns");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
